lcd_bus_arbiter: RTL and testbench
==================================

// Module: lcd_bus_arbiter
// PURPOSE
//  Owns the 4-bit HD44780 LCD bus (LCD_RS/LCD_W/LCD_E/data).
//  After reset it runs the fixed power-up init, then shares the bus between two byte-write requesters.
//  It splits each accepted byte into high then low nibble strobes, using the same 3-phase E timing as the line drivers.
//  It sits between the text sources (e.g. status line, counter line) and the LCD pins.
// PARAMETERS
//  STEP_CYCLES  1000000  clk cycles per strobe phase (>=2); simulation uses 4
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  rst_n     in   1  asynchronous, active-low reset
//  valid0    in   1  requester 0 has a byte; held until accepted
//  rs0       in   1  requester 0 register select (0=command, 1=data)
//  byte0     in   8  requester 0 byte
//  ready0    out  1  requester 0 accepted this cycle (1-cycle pulse)
//  valid1    in   1  requester 1 valid (same rules)
//  rs1       in   1  requester 1 register select
//  byte1     in   8  requester 1 byte
//  ready1    out  1  requester 1 accept pulse
//  busy      out  1  high whenever state != IDLE
//  init_done out  1  high once the init sequence has completed; sticky until reset
//  LCD_RS    out  1  LCD register select
//  LCD_W     out  1  LCD write/read; tied 0
//  LCD_E     out  1  LCD enable strobe
//  data      out  4  LCD data nibble
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=INIT, nibble ptr=0, phase=0, phase counter=0, grant ptr=0
//   - LCD_E=0, LCD_RS=0, LCD_W=0, data=4'h0, busy=1, init_done=0, ready0/1=0
//  Phase timer:
//   - Counts 0..STEP_CYCLES-1; phase advances at terminal count.
//   - Each nibble = phases P0 (E=0), P1 (drive data/RS, E=0), P2 (E=1).
//   - One nibble = 3*STEP_CYCLES cycles; LCD latches on the E fall at the P2->next transition.
//  States:
//   - INIT: sends nibbles 3,3,3,2,2,8,0,6,0,C,0,1,8,0 with RS=0.
//     14 nibbles = 42*STEP_CYCLES cycles. After the last P2 go to IDLE, E=0, init_done=1.
//   - IDLE: counter held at 0; LCD_E=0; data/RS hold last values.
//     - Only valid0: ready0=1 combinationally.
//     - Only valid1: ready1=1 combinationally.
//     - Both valid: grant ptr selects; ready=valid & selected & (state==IDLE).
//     - On accept: latch rs/byte, flip grant ptr to the other requester, next cycle go to SEND_HI at P0 with counter 0.
//   - SEND_HI: one nibble of byte[7:4] with latched RS; then SEND_LO.
//   - SEND_LO: one nibble of byte[3:0]; then IDLE (E falls on IDLE entry).
//  Timing and handshake rules:
//   - Accept-to-IDLE = 1 + 6*STEP_CYCLES cycles. Max throughput is one byte per 6*STEP_CYCLES+1 cycles.
//   - valid asserted during INIT/SEND_*: ready stays 0 and the request waits; no drop, no queue.
//   - Byte inputs are sampled only on the accept cycle; later changes are ignored.
//  Boundary conditions:
//   - Reset asserted mid-strobe (any state/phase): E drops immediately and the in-flight byte is lost. After release the full INIT re-runs.
//   - Requester deasserting valid before ready is illegal; the block is not required to handle it.
// CONFIGURATION
//  ARB_FIXED_PRIO_EN:
//   - Defined: requester 0 always wins when both are valid; grant ptr unused. Requester 1 can starve.
//   - Undefined (default): round-robin as above.
// TESTING (STEP_CYCLES=4)
//  1. Release rst_n, no valids -> 14 E pulses, 4 cycles high each, with data 3,3,3,2,2,8,0,6,0,C,0,1,8,0 and RS=0; init_done rises at cycle 168; busy falls.
//  2. After init, valid0=1 rs0=1 byte0=8'h41 -> ready0 pulses 1 cycle; data=4 then 1 with RS=1 and 2 E pulses; busy low 25 cycles after accept.
//  3. Both valid (byte0=8'h41, byte1=8'h42) held -> served 0 then 1 then 0...; with ARB_FIXED_PRIO_EN, only 0 served while valid0 stays high.
//  4. valid1=1 (byte1=8'hC0, rs1=0) asserted at cycle 10 during INIT -> ready1 stays 0 until IDLE; then nibbles C,0 sent with RS=0.
//  5. rst_n low during SEND_HI P2 -> same cycle LCD_E=0, data=0, busy=1, init_done=0; after release INIT restarts from nibble 3.
//  6. LCD_W checked 0 on every cycle of all scenarios.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: owns the 4-bit HD44780 bus. Runs the power-up init
// sequence after reset, then serves byte writes from two requesters. Each
// byte goes out as a high-nibble strobe followed by a low-nibble strobe.
// Every nibble strobe has three phases of STEP_CYCLES clocks each:
// P0 (E low), P1 (data/RS driven, E low) and P2 (E high).
// Optional build macro ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
// Without it, ties are broken round-robin.
module lcd_bus_arbiter #(
    parameter int STEP_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid0,
    input  logic       rs0,
    input  logic [7:0] byte0,
    output logic       ready0,
    input  logic       valid1,
    input  logic       rs1,
    input  logic [7:0] byte1,
    output logic       ready1,
    output logic       busy,
    output logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_W,
    output logic       LCD_E,
    output logic [3:0] data
);
    localparam int CW = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);
    localparam logic [3:0] LAST_INIT = 4'd13;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND_HI, ST_SEND_LO} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      phase_q, phase_d;
    logic [3:0]      nib_q, nib_d;
    logic [3:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic [7:0]      byte_q, byte_d;
    logic            rsl_q, rsl_d;
    logic            init_done_q, init_done_d;
    logic            sel1;
    logic [3:0]      cur_nib;
    logic            cur_rs;
`ifndef ARB_FIXED_PRIO_EN
    logic            grant_q, grant_d;
`endif

    // Init nibbles: 8-bit/4-bit wake-up, function set, display on, clear, entry mode.
    function automatic logic [3:0] init_nibble(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd2: init_nibble = 4'h3;
            4'd3, 4'd4:       init_nibble = 4'h2;
            4'd5, 4'd12:      init_nibble = 4'h8;
            4'd7:             init_nibble = 4'h6;
            4'd9:             init_nibble = 4'hC;
            4'd11:            init_nibble = 4'h1;
            default:          init_nibble = 4'h0;
        endcase
    endfunction

    // Tie-break: select requester 1 when only it is valid, or when both are and it is its turn.
`ifdef ARB_FIXED_PRIO_EN
    assign sel1 = valid1 & ~valid0;
`else
    assign sel1 = valid1 & (~valid0 | grant_q);
`endif

    // Next-state: arbitration in IDLE, phase/nibble sequencing elsewhere.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        nib_d       = nib_q;
        data_d      = data_q;
        rs_d        = rs_q;
        byte_d      = byte_q;
        rsl_d       = rsl_q;
        init_done_d = init_done_q;
        ready0      = 1'b0;
        ready1      = 1'b0;
        cur_nib     = 4'h0;
        cur_rs      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
        grant_d     = grant_q;
`endif
        case (state_q)
            ST_INIT:    cur_nib = init_nibble(nib_q);
            ST_SEND_HI: begin cur_nib = byte_q[7:4]; cur_rs = rsl_q; end
            ST_SEND_LO: begin cur_nib = byte_q[3:0]; cur_rs = rsl_q; end
            default:    ;
        endcase

        if (state_q == ST_IDLE) begin
            cnt_d   = '0;
            phase_d = 2'd0;
            ready0  = valid0 & ~sel1;
            ready1  = valid1 & sel1;
            if (ready0 | ready1) begin
                byte_d  = ready1 ? byte1 : byte0;
                rsl_d   = ready1 ? rs1 : rs0;
                state_d = ST_SEND_HI;
`ifndef ARB_FIXED_PRIO_EN
                grant_d = ready0;  // next tie goes to the one not just served
`endif
            end
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            case (phase_q)
                2'd0: begin
                    phase_d = 2'd1;
                    data_d  = cur_nib;
                    rs_d    = cur_rs;
                end
                2'd1: phase_d = 2'd2;
                default: begin
                    // End of P2: E falls here and the LCD latches the nibble.
                    phase_d = 2'd0;
                    case (state_q)
                        ST_INIT: begin
                            if (nib_q == LAST_INIT) begin
                                nib_d       = 4'd0;
                                state_d     = ST_IDLE;
                                init_done_d = 1'b1;
                            end else begin
                                nib_d = nib_q + 4'd1;
                            end
                        end
                        ST_SEND_HI: state_d = ST_SEND_LO;
                        default:    state_d = ST_IDLE;
                    endcase
                end
            endcase
        end
    end

    // State registers; reset restarts the init sequence and kills any strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            phase_q     <= 2'd0;
            nib_q       <= 4'd0;
            data_q      <= 4'h0;
            rs_q        <= 1'b0;
            byte_q      <= 8'h00;
            rsl_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            nib_q       <= nib_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            byte_q      <= byte_d;
            rsl_q       <= rsl_d;
            init_done_q <= init_done_d;
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin pointer: 0 favours requester 0 on a tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) grant_q <= 1'b0;
        else        grant_q <= grant_d;
    end
`endif

    assign busy      = (state_q != ST_IDLE);
    assign LCD_E     = busy & (phase_q == 2'd2);
    assign LCD_RS    = rs_q;
    assign LCD_W     = 1'b0;
    assign data      = data_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with STEP_CYCLES=4. A negedge monitor
// captures each E pulse as {RS,data} plus its high length; the scenario tasks
// compare those captures and the handshake timing against hand-derived values.
module tb_lcd_bus_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid0 = 1'b0, rs0 = 1'b0, valid1 = 1'b0, rs1 = 1'b0;
    logic [7:0] byte0 = 8'h00, byte1 = 8'h00;
    logic       ready0, ready1, busy, init_done, LCD_RS, LCD_W, LCD_E;
    logic [3:0] data;

    int         n_checks = 0;
    int         n_fails = 0;
    int         w_errs = 0;
    logic [4:0] cap[$];
    int         lens[$];
    logic       e_prev = 1'b0;
    int         e_len = 0;
    logic [3:0] init_tab[14];

    lcd_bus_arbiter #(.STEP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid0(valid0), .rs0(rs0), .byte0(byte0), .ready0(ready0),
        .valid1(valid1), .rs1(rs1), .byte1(byte1), .ready1(ready1),
        .busy(busy), .init_done(init_done),
        .LCD_RS(LCD_RS), .LCD_W(LCD_W), .LCD_E(LCD_E), .data(data)
    );

    always #5 clk = ~clk;

    // Pulse capture and LCD_W watch, sampled on the falling edge.
    always @(negedge clk) begin
        if (LCD_W !== 1'b0) w_errs++;
        if (!rst_n) begin
            e_prev = 1'b0;
            e_len  = 0;
        end else if (LCD_E === 1'b1) begin
            if (!e_prev) begin
                cap.push_back({LCD_RS, data});
                e_len = 0;
            end
            e_len++;
            e_prev = 1'b1;
        end else begin
            if (e_prev) lens.push_back(e_len);
            e_prev = 1'b0;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (LCD_E !== 1'b0) begin n_fails++; $display("FAIL reset_e: got %b want 0", LCD_E); end
        n_checks++; if (LCD_RS !== 1'b0) begin n_fails++; $display("FAIL reset_rs: got %b want 0", LCD_RS); end
        n_checks++; if (data !== 4'h0) begin n_fails++; $display("FAIL reset_data: got %h want 0", data); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL reset_busy: got %b want 1", busy); end
        n_checks++; if (init_done !== 1'b0) begin n_fails++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_checks++; if ({ready0, ready1} !== 2'b00) begin n_fails++; $display("FAIL reset_ready: got %b want 00", {ready0, ready1}); end
    endtask

    task automatic test_init();
        int n;
        cap.delete(); lens.delete();
        @(negedge clk) rst_n = 1'b1;
        n = 0;
        while (init_done !== 1'b1 && n < 300) begin
            @(posedge clk); n++; @(negedge clk);
        end
        n_checks++; if (n != 168) begin n_fails++; $display("FAIL init_done_cycle: got %0d want 168", n); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL init_busy: got %b want 0", busy); end
        @(negedge clk);
        n_checks++;
        if (cap.size() != 14 || lens.size() != 14) begin
            n_fails++; $display("FAIL init_pulses: got %0d/%0d want 14", cap.size(), lens.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                n_checks++;
                if (cap[i] !== {1'b0, init_tab[i]} || lens[i] != 4) begin
                    n_fails++;
                    $display("FAIL init_nibble%0d: got rs/data %h len %0d want %h len 4", i, cap[i], lens[i], {1'b0, init_tab[i]});
                end
            end
        end
        n_checks++; if (w_errs != 0) begin n_fails++; $display("FAIL lcd_w_init: %0d cycles nonzero want 0", w_errs); end
    endtask

    task automatic test_single();
        int n;
        cap.delete(); lens.delete();
        @(posedge clk) #1;
        valid0 = 1'b1; rs0 = 1'b1; byte0 = 8'h41;
        n = 0;
        @(negedge clk);
        while (ready0 !== 1'b1 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        n_checks++; if (ready0 !== 1'b1) begin n_fails++; $display("FAIL single_ready: got %b want 1", ready0); end
        n = 0;
        @(posedge clk); n++; #1;
        valid0 = 1'b0; byte0 = 8'hFF; rs0 = 1'b0;  // must be ignored now
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b0) begin n_fails++; $display("FAIL single_ready_pulse: got %b want 0", ready0); end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL single_busy: got %b want 1", busy); end
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); n++; @(negedge clk);
        end
        n_checks++; if (n != 25) begin n_fails++; $display("FAIL single_latency: got %0d want 25", n); end
        @(negedge clk);
        n_checks++;
        if (cap.size() != 2 || lens.size() != 2) begin
            n_fails++; $display("FAIL single_pulses: got %0d want 2", cap.size());
        end else if (cap[0] !== 5'h14 || cap[1] !== 5'h11 || lens[0] != 4 || lens[1] != 4) begin
            n_fails++; $display("FAIL single_nibbles: got %h %h len %0d %0d want 14 11 len 4 4", cap[0], cap[1], lens[0], lens[1]);
        end
        n_checks++; if ({LCD_RS, data} !== 5'h11) begin n_fails++; $display("FAIL single_hold: got %h want 11", {LCD_RS, data}); end
        n_checks++; if (w_errs != 0) begin n_fails++; $display("FAIL lcd_w_single: %0d cycles nonzero want 0", w_errs); end
    endtask

    task automatic test_mid_reset();
        cap.delete(); lens.delete();
        @(posedge clk) #1;
        valid0 = 1'b1; rs0 = 1'b1; byte0 = 8'hA5;
        @(negedge clk);
        n_checks++; if (ready0 !== 1'b1) begin n_fails++; $display("FAIL midrst_accept: got %b want 1", ready0); end
        @(posedge clk) #1 valid0 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({LCD_E, LCD_RS, data} !== 6'h3A) begin n_fails++; $display("FAIL midrst_p2: got e/rs/data %h want 3a", {LCD_E, LCD_RS, data}); end
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (LCD_E !== 1'b0) begin n_fails++; $display("FAIL midrst_e: got %b want 0", LCD_E); end
        n_checks++; if (data !== 4'h0) begin n_fails++; $display("FAIL midrst_data: got %h want 0", data); end
        n_checks++; if (busy !== 1'b1 || init_done !== 1'b0) begin n_fails++; $display("FAIL midrst_status: got busy %b init_done %b want 1 0", busy, init_done); end
    endtask

    task automatic test_init_wait();
        int n;
        int early;
        repeat (2) @(negedge clk);
        cap.delete(); lens.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1 valid1 = 1'b1; rs1 = 1'b0; byte1 = 8'hC0;
        n = 10; early = 0;
        @(negedge clk);
        while (init_done !== 1'b1 && n < 300) begin
            if (ready1 !== 1'b0) early++;
            @(posedge clk); n++; @(negedge clk);
        end
        n_checks++; if (early != 0) begin n_fails++; $display("FAIL wait_ready_early: %0d cycles high want 0", early); end
        n_checks++; if (n != 168) begin n_fails++; $display("FAIL wait_init_cycle: got %0d want 168", n); end
        n_checks++; if (ready1 !== 1'b1) begin n_fails++; $display("FAIL wait_ready_idle: got %b want 1", ready1); end
        @(posedge clk) #1 valid1 = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); n++; @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (cap.size() != 16) begin
            n_fails++; $display("FAIL wait_pulses: got %0d want 16", cap.size());
        end else begin
            for (int i = 0; i < 14; i++) begin
                n_checks++;
                if (cap[i] !== {1'b0, init_tab[i]}) begin n_fails++; $display("FAIL reinit_nibble%0d: got %h want %h", i, cap[i], {1'b0, init_tab[i]}); end
            end
            n_checks++;
            if (cap[14] !== 5'h0C || cap[15] !== 5'h00) begin n_fails++; $display("FAIL wait_nibbles: got %h %h want 0c 00", cap[14], cap[15]); end
        end
        n_checks++; if (w_errs != 0) begin n_fails++; $display("FAIL lcd_w_wait: %0d cycles nonzero want 0", w_errs); end
    endtask

    task automatic test_round_robin();
        int n;
        logic [2:0] who;
        logic [2:0] want;
        logic [4:0] exp_lo[3];
`ifdef ARB_FIXED_PRIO_EN
        want = 3'b000;
`else
        want = 3'b010;  // bit i = requester served on accept i
`endif
        cap.delete(); lens.delete();
        who = 3'b000;
        @(posedge clk) #1;
        valid0 = 1'b1; rs0 = 1'b1; byte0 = 8'h41;
        valid1 = 1'b1; rs1 = 1'b1; byte1 = 8'h42;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            @(negedge clk);
            while (!(ready0 === 1'b1 || ready1 === 1'b1) && n < 40) begin
                @(posedge clk); n++; @(negedge clk);
            end
            n_checks++; if ({ready0, ready1} !== 2'b10 && {ready0, ready1} !== 2'b01) begin n_fails++; $display("FAIL rr_grant%0d: got ready %b want one-hot", k, {ready0, ready1}); end
            who[k] = ready1;
            @(posedge clk);
            if (k == 2) begin #1 valid0 = 1'b0; valid1 = 1'b0; end
        end
        n_checks++; if (who !== want) begin n_fails++; $display("FAIL rr_order: got %b want %b", who, want); end
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); n++; @(negedge clk);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) exp_lo[k] = want[k] ? 5'h12 : 5'h11;
        n_checks++;
        if (cap.size() != 6) begin
            n_fails++; $display("FAIL rr_pulses: got %0d want 6", cap.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (cap[2*k] !== 5'h14 || cap[2*k+1] !== exp_lo[k]) begin
                    n_fails++; $display("FAIL rr_byte%0d: got %h %h want 14 %h", k, cap[2*k], cap[2*k+1], exp_lo[k]);
                end
            end
        end
        n_checks++; if (w_errs != 0) begin n_fails++; $display("FAIL lcd_w_rr: %0d cycles nonzero want 0", w_errs); end
    endtask

    initial begin
        init_tab = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1, 4'h8, 4'h0};
        test_reset();
        test_init();
        test_single();
        test_mid_reset();
        test_init_wait();
        test_round_robin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
